xor_lfsr_scrambler: RTL and testbench

- Parametrised, registered XOR datapath: each accepted input word is XORed with a W-bit keystream from an internal Fibonacci LFSR.
- Additive scrambler/descrambler; the same block does both directions.
- Used on serial-link and test-pattern paths next to the combinational XOR cells.
- Valid/ready in, valid/ready out, one register stage.

---
 rtl/xor_lfsr_scrambler.sv | 100 ++++++++++
 tb/tb_xor_lfsr_scrambler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/xor_lfsr_scrambler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xor_lfsr_scrambler: registered additive scrambler/descrambler; each word   |
// | is XORed with W keystream bits from a Fibonacci LFSR. Optional feature     |
// | macro XOR_SCR_BYPASS_EN adds a bypass input.            Revision 1.0       |
// +----------------------------------------------------------------------------+
module xor_lfsr_scrambler #(
  parameter int unsigned  W    = 8,
  parameter int unsigned  N    = 7,
  parameter logic [N-1:0] POLY = N'(7'h60),
  parameter logic [N-1:0] SEED = N'(7'h7F)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_data,
  input  logic         seed_load,
  input  logic [N-1:0] seed,
`ifdef XOR_SCR_BYPASS_EN
  input  logic         bypass,
`endif
  output logic         q_valid,
  input  logic         q_ready,
  output logic [W-1:0] q
);

  logic [N-1:0] lfsr_q, lfsr_d;
  logic [W-1:0] q_q, q_d;
  logic         q_valid_q, q_valid_d;

  logic [W-1:0] ks;
  logic [N-1:0] lfsr_adv;
  logic [N-1:0] seed_safe;
  logic         accept;
  logic         byp;

`ifdef XOR_SCR_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  assign i_ready   = ~q_valid_q | q_ready;
  assign accept    = i_valid & i_ready;
  // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
  assign seed_safe = (seed == '0) ? N'(1) : seed;

  // W LFSR steps unrolled; keystream bit k is the feedback bit of step k.
  always_comb begin
    logic [N-1:0] s;
    logic         f;
    s  = lfsr_q;
    ks = '0;
    for (int k = 0; k < int'(W); k++) begin
      f     = ^(s & POLY);
      ks[k] = f;
      s     = {s[N-2:0], f};
    end
    lfsr_adv = s;
  end

  always_comb begin
    lfsr_d    = lfsr_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    if (accept) begin
      q_valid_d = 1'b1;
      if (byp) begin
        q_d = i_data;
      end else begin
        q_d    = i_data ^ ks;
        lfsr_d = lfsr_adv;
      end
    end else if (q_ready) begin
      q_valid_d = 1'b0;
    end
    // The accepted word above already used the old state; the load wins.
    if (seed_load) begin
      lfsr_d = seed_safe;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      lfsr_q    <= SEED;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_lfsr_scrambler.sv
`default_nettype none
// Bench for xor_lfsr_scrambler: directed test-plan steps followed by random
// traffic checked against a bit-history model of the keystream.
module tb_xor_lfsr_scrambler;

  localparam int unsigned W = 8;
  localparam int unsigned N = 7;
  localparam logic [N-1:0] POLY = 7'h60;
  localparam logic [N-1:0] SEED = 7'h7F;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] i_data = '0;
  logic         seed_load = 1'b0;
  logic [N-1:0] seed = '0;
  logic         bypass = 1'b0;
  logic         q_valid;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;

  int checks = 0;
  int errors = 0;

  xor_lfsr_scrambler #(.W(W), .N(N), .POLY(POLY), .SEED(SEED)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_data    (i_data),
    .seed_load (seed_load),
    .seed      (seed),
`ifdef XOR_SCR_BYPASS_EN
    .bypass    (bypass),
`endif
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q         (q)
  );

  always #5 clk = ~clk;

  // Model: the generated bit stream, oldest first; LFSR bit j is the bit
  // emitted j steps before the newest one.
  bit           hist[$];
  logic [W-1:0] m_q;
  bit           m_qv;

  function automatic void load_hist(input logic [N-1:0] v);
    hist.delete();
    for (int j = N - 1; j >= 0; j--) hist.push_back(v[j]);
  endfunction

  function automatic logic [N-1:0] model_state();
    logic [N-1:0] s;
    for (int j = 0; j < int'(N); j++) s[j] = hist[hist.size() - 1 - j];
    return s;
  endfunction

  function automatic bit next_bit();
    bit f = 1'b0;
    for (int j = 0; j < int'(N); j++)
      if (POLY[j]) f ^= hist[hist.size() - 1 - j];
    return f;
  endfunction

  task automatic model_step(input bit rn, input bit iv, input logic [W-1:0] d,
                            input bit sl, input logic [N-1:0] sd, input bit qr,
                            input bit byp);
    bit acc;
    logic [W-1:0] ks;
    acc = iv && (!m_qv || qr);
    if (!rn) begin
      load_hist(SEED);
      m_qv = 1'b0;
      m_q  = '0;
      return;
    end
    if (acc) begin
      if (byp) begin
        m_q = d;
      end else begin
        for (int k = 0; k < int'(W); k++) begin
          ks[k] = next_bit();
          hist.push_back(ks[k]);
          void'(hist.pop_front());
        end
        m_q = d ^ ks;
      end
      m_qv = 1'b1;
    end else if (qr) begin
      m_qv = 1'b0;
    end
    if (sl) load_hist((sd == '0) ? N'(1) : sd);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check i_ready before the edge, advance model, check after.
  task automatic cyc(input string tag, input bit rn, input bit iv, input logic [W-1:0] d,
                     input bit sl, input logic [N-1:0] sd, input bit qr, input bit byp);
    nrst = rn; i_valid = iv; i_data = d; seed_load = sl; seed = sd; q_ready = qr;
    bypass = byp;
    #1;
    if (rn) check({tag, ".i_ready"}, 64'(i_ready), 64'(!m_qv || qr));
    model_step(rn, iv, d, sl, sd, qr, byp);
    @(posedge clk);
    #1;
    check({tag, ".q_valid"}, 64'(q_valid), 64'(m_qv));
    check({tag, ".q"}, 64'(q), 64'(m_q));
    check({tag, ".lfsr"}, 64'(dut.lfsr_q), 64'(model_state()));
  endtask

  logic [W-1:0] rt[16];

  initial begin
    load_hist(SEED);
    m_q = '0; m_qv = 1'b0;
    #2;

    // Reset state and the first two words.
    cyc("rst", 0, 0, 8'h00, 0, 7'h00, 1, 0);
    cyc("rst2", 0, 0, 8'h00, 0, 7'h00, 1, 0);
    check("rst_lfsr", 64'(dut.lfsr_q), 64'h7F);
    cyc("w1", 1, 1, 8'h00, 0, 7'h00, 1, 0);
    check("w1_q", 64'(q), 64'h40);
    check("w1_lfsr", 64'(dut.lfsr_q), 64'h02);
    cyc("w2", 1, 1, 8'h00, 0, 7'h00, 1, 0);
    check("w2_q", 64'(q), 64'h30);
    check("w2_lfsr", 64'(dut.lfsr_q), 64'h0C);
    check("w2_qv", 64'(q_valid), 64'h1);

    // Backpressure: stall three cycles then release.
    cyc("bp_rst", 0, 0, 8'h00, 0, 7'h00, 1, 0);
    cyc("bp_w1", 1, 1, 8'h00, 0, 7'h00, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("bp_stall", 1, 1, 8'h00, 0, 7'h00, 0, 0);
      check("bp_ready", 64'(i_ready), 64'h0);
      check("bp_hold_q", 64'(q), 64'h40);
      check("bp_hold_lfsr", 64'(dut.lfsr_q), 64'h02);
    end
    cyc("bp_rel", 1, 1, 8'h00, 0, 7'h00, 1, 0);
    check("bp_rel_q", 64'(q), 64'h30);

    // Zero-seed guard, then seed load alongside an accept.
    cyc("seed0", 1, 0, 8'h00, 1, 7'h00, 1, 0);
    check("seed0_lfsr", 64'(dut.lfsr_q), 64'h01);
    cyc("sl_rst", 0, 0, 8'h00, 0, 7'h00, 1, 0);
    cyc("sl_acc", 1, 1, 8'h00, 1, 7'h15, 1, 0);
    check("sl_acc_q", 64'(q), 64'h40);
    check("sl_acc_lfsr", 64'(dut.lfsr_q), 64'h15);

    // Reset while a word is held under backpressure.
    cyc("rs_rst", 0, 0, 8'h00, 0, 7'h00, 1, 0);
    cyc("rs_w", 1, 1, 8'h3C, 0, 7'h00, 0, 0);
    cyc("rs_stall", 1, 1, 8'h11, 0, 7'h00, 0, 0);
    cyc("rs_hit", 0, 1, 8'h22, 0, 7'h00, 0, 0);
    check("rs_qv", 64'(q_valid), 64'h0);
    check("rs_q", 64'(q), 64'h0);
    check("rs_lfsr", 64'(dut.lfsr_q), 64'h7F);

    // Round trip: scramble, reload the seed, descramble.
    cyc("rt_rst", 0, 0, 8'h00, 0, 7'h00, 1, 0);
    for (int i = 0; i < 16; i++) begin
      cyc("rt_scr", 1, 1, 8'hA5, 0, 7'h00, 1, 0);
      rt[i] = q;
    end
    cyc("rt_reload", 1, 0, 8'h00, 1, 7'h7F, 1, 0);
    for (int i = 0; i < 16; i++) begin
      cyc("rt_dscr", 1, 1, rt[i], 0, 7'h00, 1, 0);
      check("rt_plain", 64'(q), 64'hA5);
    end

`ifdef XOR_SCR_BYPASS_EN
    cyc("byp_rst", 0, 0, 8'h00, 0, 7'h00, 1, 0);
    cyc("byp", 1, 1, 8'h5A, 0, 7'h00, 1, 1);
    check("byp_q", 64'(q), 64'h5A);
    check("byp_lfsr", 64'(dut.lfsr_q), 64'h7F);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit rn, iv, sl, qr, byp;
      logic [W-1:0] d;
      logic [N-1:0] sd;
      rn  = ($urandom_range(0, 49) != 0);
      iv  = ($urandom_range(0, 3) != 0);
      qr  = ($urandom_range(0, 2) != 0);
      sl  = ($urandom_range(0, 15) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      d   = W'($urandom);
`ifdef XOR_SCR_BYPASS_EN
      byp = ($urandom_range(0, 4) == 0);
`else
      byp = 1'b0;
`endif
      cyc("rand", rn, iv, d, sl, sd, qr, byp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
